// File: rtl/tcdm_rr_arbiter_pkg.sv
// Shared types and the round-robin priority pick used by the TCDM arbiter.
package tcdm_arb_pkg;

    localparam int DEFAULT_NUM_MASTERS = 4;
    localparam int MAX_MASTERS         = 32;
    localparam int PICK_IDX_W          = 5;
    localparam int PICK_N_W            = 6;

    typedef logic [$clog2(DEFAULT_NUM_MASTERS)-1:0] idx_t;

    // Index of the first set bit in req[0..n-1], scanning upward from ptr and
    // wrapping modulo n. Scans high offsets first so the lowest offset wins.
    function automatic logic [PICK_IDX_W-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [PICK_N_W-1:0]    n,
        input logic [PICK_IDX_W-1:0]  ptr
    );
        logic [PICK_N_W-1:0]   sum;
        logic [PICK_IDX_W-1:0] pick;
        pick = '0;
        for (int k = MAX_MASTERS - 1; k >= 0; k--) begin
            if (PICK_N_W'(k) < n) begin
                sum = {1'b0, ptr} + PICK_N_W'(k);
                if (sum >= n) begin
                    sum = sum - n;
                end
                if (req[sum[PICK_IDX_W-1:0]]) begin
                    pick = sum[PICK_IDX_W-1:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tcdm_rr_arbiter_id_fifo.sv
// Synchronous FIFO holding the master index of every outstanding read.
module tcdm_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [2**AW];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr - rd_ptr) == (AW+1)'(DEPTH));
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/tcdm_rr_arbiter.sv
// N-to-1 round-robin TCDM arbiter with in-order read response routing.
module tcdm_rr_arbiter
    import tcdm_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                clk_i,
    input  logic                                resetn_i,
    input  logic [NUM_MASTERS-1:0]              m_req_i,
    output logic [NUM_MASTERS-1:0]              m_gnt_o,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [NUM_MASTERS-1:0]              m_wen_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_data_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
    output logic [DATA_WIDTH-1:0]               m_r_data_o,
    output logic [NUM_MASTERS-1:0]              m_r_valid_o,
    input  logic [NUM_MASTERS-1:0]              m_r_ready_i,
    output logic                                s_req_o,
    input  logic                                s_gnt_i,
    output logic [ADDR_WIDTH-1:0]               s_addr_o,
    output logic                                s_wen_o,
    output logic [DATA_WIDTH-1:0]               s_data_o,
    output logic [DATA_WIDTH/8-1:0]             s_be_o,
    input  logic [DATA_WIDTH-1:0]               s_r_data_i,
    input  logic                                s_r_valid_i,
    output logic                                s_r_ready_o,
    output logic                                err_o
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int BW = DATA_WIDTH / 8;

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] winner;
    logic [IW-1:0] head;
    logic          any_req;
    logic          can_issue;
    logic          req_hs;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;

    assign winner  = IW'(rr_pick(MAX_MASTERS'(m_req_i), PICK_N_W'(NUM_MASTERS),
                                 PICK_IDX_W'(rr_ptr)));
    assign any_req = |m_req_i;

    // Full blocks reads from registered status only; a same-cycle pop does not unblock.
    assign can_issue = ~fifo_full | m_wen_i[winner];
    assign s_req_o   = any_req & can_issue;

    always_comb begin
        s_addr_o = '0;
        s_wen_o  = 1'b0;
        s_data_o = '0;
        s_be_o   = '0;
        if (any_req) begin
            s_addr_o = m_addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
            s_wen_o  = m_wen_i[winner];
            s_data_o = m_data_i[winner*DATA_WIDTH +: DATA_WIDTH];
            s_be_o   = m_be_i[winner*BW +: BW];
        end
    end

    // Valid/ready: a request transfers when s_req_o & s_gnt_i; a response when
    // s_r_valid_i & s_r_ready_o. Neither side may retract its offer on account of the other.
    assign req_hs  = s_req_o & s_gnt_i;
    assign m_gnt_o = req_hs ? (NUM_MASTERS'(1) << winner) : '0;
    assign push    = req_hs & ~m_wen_i[winner];
    assign pop     = s_r_valid_i & s_r_ready_o;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rr_ptr <= '0;
        end else if (req_hs) begin
            rr_ptr <= (winner == IW'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
        end
    end

    tcdm_id_fifo #(
        .DEPTH(MAX_OUTSTANDING),
        .WIDTH(IW)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .push     (push),
        .push_data(winner),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head)
    );

    assign m_r_data_o  = s_r_data_i;
    assign m_r_valid_o = (s_r_valid_i & ~fifo_empty) ? (NUM_MASTERS'(1) << head) : '0;
    assign s_r_ready_o = m_r_ready_i[head] & ~fifo_empty;

    // A response with nothing outstanding is dropped and latched as an error.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            err_o <= 1'b0;
        end else if (s_r_valid_i & fifo_empty) begin
            err_o <= 1'b1;
        end
    end

endmodule
